ws2812_frame_ctrl: RTL
======================

Name: ws2812_frame_ctrl

Overview:
- Frame-level controller for the WS2812 reshaper stage.
- Watches the synced encoder stream and drives the reshaper enable, so the reshaper passes only frames that start on a clean latch boundary.
- Counts bits per frame against a configured pixel count and flags short or overrun frames.
- Sits between the input synchronizer and the reshaper; its enable output feeds the reshaper configuration struct's enable field.

Parameters:
- LATCH_CYCLES, 4000, consecutive low cycles that define a frame boundary (50 us at 80 MHz); must be ≥2.
- CNT_WIDTH, 13, width of the low-run counter; must satisfy 2^CNT_WIDTH > LATCH_CYCLES.
- BITS_PER_PIXEL, 24, bits per pixel (GRB).
- PIX_WIDTH, 12, width of the pixel-count configuration.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_signal  in  1  synced encoder stream (same net the reshaper sees)
- i_cfg_enable  in  1  software enable for the channel
- i_cfg_pixels  in  PIX_WIDTH  expected pixels per frame
- o_reshaper_enable  out  1  drives the reshaper enable
- o_frame_active  out  1  high while a frame is in progress
- o_frame_done  out  1  1-cycle pulse: frame ended with the exact bit count
- o_frame_error  out  1  1-cycle pulse: short frame or overrun
- o_bit_count  out  PIX_WIDTH+5  bits received in the current/last frame
- o_frame_count  out  16  frames completed (stats, see Optional Feature)
- o_error_count  out  8  errors seen (stats, see Optional Feature)

Behaviour:
- Reset: all outputs 0; state DISABLED; low-run counter 0; edge register 0.
- Rising edge: i_signal & ~r_sig_d, where r_sig_d is i_signal registered.
- Low-run counter:
  - Clears on any cycle with i_signal=1.
  - Otherwise increments, saturating at LATCH_CYCLES.
  - "Latch seen" = counter == LATCH_CYCLES-1 with i_signal=0, i.e. the LATCH_CYCLES-th consecutive low cycle.
- Outputs decoded from the state register (Moore):
  - o_reshaper_enable = 1 in READY or ACTIVE.
  - o_frame_active = 1 in ACTIVE.
- DISABLED: i_cfg_enable=1 -> SYNC; the low-run counter is cleared on entry.
- SYNC: enable 0.
  - Latch seen -> READY.
  - i_cfg_enable=0 -> DISABLED.
  - Entering mid-frame therefore discards the rest of that frame.
- READY: enable 1.
  - Rising edge -> ACTIVE; bit_count <= 1; i_cfg_pixels captured into r_expected = pixels*BITS_PER_PIXEL.
  - i_cfg_enable=0 -> DISABLED.
- ACTIVE: rising edge increments bit_count.
  - Overrun: a rising edge when bit_count == r_expected. o_frame_error pulses, bit_count holds, -> SYNC. Enable drops the next cycle, and the reshaper forces its output low from then on.
  - Latch seen: -> READY (or DISABLED if i_cfg_enable=0). o_frame_done pulses if bit_count == r_expected; otherwise o_frame_error pulses (short frame).
  - A deasserted i_cfg_enable in ACTIVE does not abort; the frame finishes first.
- Boundary rules:
  - i_cfg_pixels = 0: the first edge after capture is an overrun.
  - bit_count is not cleared at frame end; it stays visible until the next frame's first edge.
  - Changes to i_cfg_pixels in ACTIVE are ignored until the next frame.
  - Latch seen and i_cfg_enable fall in the same cycle: the done/error pulse is still issued.
- Pulses are registered: they are asserted in the cycle after the qualifying condition, coincident with the new state.
- Reset asserted mid-frame: immediate return to reset values; enable drops asynchronously.

Optional Feature:
- Macro WS2812_FRAME_CTRL_STATS_EN.
- Defined:
  - o_frame_count increments on each o_frame_done, wrapping at 2^16.
  - o_error_count increments on each o_frame_error, saturating at 255.
  - Both clear only on reset.
- Undefined: both outputs tied to constant 0; no counter flops.

Test Plan (LATCH_CYCLES=8, PIX_WIDTH=4):
- Reset held with i_signal toggling -> every output 0; after release with i_cfg_enable=0, state stays DISABLED and enable stays 0.
- Enable asserted with i_signal low -> enable rises on cycle 8 after SYNC entry; a high on cycle 5 restarts the 8-cycle count.
- pixels=1, 24 edges, then 8 low cycles -> o_frame_done 1 pulse; bit_count=24; back to READY with enable high.
- pixels=1, 20 edges, then latch -> o_frame_error pulse; bit_count=20; no done pulse.
- pixels=1, 25th edge -> o_frame_error pulse; enable 0 the following cycle; 8 low cycles required to re-enter READY.
- i_cfg_enable dropped after edge 10 of a 24-bit frame -> frame completes with done pulse, then DISABLED; with STATS_EN, frame_count=1.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// Frame-boundary gate for the WS2812 reshaper: enables it only between clean latch gaps.
// Optional frame/error statistics are built when WS2812_FRAME_CTRL_STATS_EN is defined.
module ws2812_frame_ctrl #(
  parameter int LATCH_CYCLES   = 4000,
  parameter int CNT_WIDTH      = 13,
  parameter int BITS_PER_PIXEL = 24,
  parameter int PIX_WIDTH      = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_signal,
  input  logic                 i_cfg_enable,
  input  logic [PIX_WIDTH-1:0] i_cfg_pixels,
  output logic                 o_reshaper_enable,
  output logic                 o_frame_active,
  output logic                 o_frame_done,
  output logic                 o_frame_error,
  output logic [PIX_WIDTH+4:0] o_bit_count,
  output logic [15:0]          o_frame_count,
  output logic [7:0]           o_error_count
);

  localparam int BC_WIDTH = PIX_WIDTH + 5;
  localparam logic [CNT_WIDTH-1:0] LATCH_MAX  = CNT_WIDTH'(LATCH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LATCH_LAST = CNT_WIDTH'(LATCH_CYCLES - 1);
  localparam logic [BC_WIDTH-1:0]  BPP        = BC_WIDTH'(BITS_PER_PIXEL);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_READY    = 2'd2,
    ST_ACTIVE   = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  sig_d_reg;
  logic [CNT_WIDTH-1:0]  low_cnt_reg;
  logic [BC_WIDTH-1:0]   bit_count_reg, bit_count_next;
  logic [BC_WIDTH-1:0]   expected_reg, expected_next;
  logic                  done_reg, done_next;
  logic                  error_reg, error_next;
  logic                  low_clear;
  logic                  rise;
  logic                  latch_seen;

  assign rise       = i_signal & ~sig_d_reg;
  assign latch_seen = ~i_signal && (low_cnt_reg == LATCH_LAST);

  // Low-run counter: restarts on any high and on DISABLED->SYNC so sync always sees a full gap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sig_d_reg   <= 1'b0;
      low_cnt_reg <= '0;
    end else begin
      sig_d_reg <= i_signal;
      if (low_clear || i_signal)
        low_cnt_reg <= '0;
      else if (low_cnt_reg != LATCH_MAX)
        low_cnt_reg <= low_cnt_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= ST_DISABLED;
      bit_count_reg <= '0;
      expected_reg  <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_count_reg <= bit_count_next;
      expected_reg  <= expected_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_count_next = bit_count_reg;
    expected_next  = expected_reg;
    done_next      = 1'b0;
    error_next     = 1'b0;
    low_clear      = 1'b0;
    case (state_reg)
      ST_DISABLED: begin
        if (i_cfg_enable) begin
          state_next = ST_SYNC;
          low_clear  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (!i_cfg_enable)
          state_next = ST_DISABLED;
        else if (latch_seen)
          state_next = ST_READY;
      end
      ST_READY: begin
        if (!i_cfg_enable) begin
          state_next = ST_DISABLED;
        end else if (rise) begin
          state_next     = ST_ACTIVE;
          bit_count_next = BC_WIDTH'(1);
          expected_next  = BC_WIDTH'(i_cfg_pixels) * BPP;
        end
      end
      ST_ACTIVE: begin
        // >= so that a zero-pixel frame overruns on its second edge
        if (rise) begin
          if (bit_count_reg >= expected_reg) begin
            error_next = 1'b1;
            state_next = ST_SYNC;
          end else begin
            bit_count_next = bit_count_reg + BC_WIDTH'(1);
          end
        end else if (latch_seen) begin
          state_next = i_cfg_enable ? ST_READY : ST_DISABLED;
          if (bit_count_reg == expected_reg)
            done_next = 1'b1;
          else
            error_next = 1'b1;
        end
      end
      default: state_next = ST_DISABLED;
    endcase
  end

  always_comb begin
    o_reshaper_enable = (state_reg == ST_READY) || (state_reg == ST_ACTIVE);
    o_frame_active    = (state_reg == ST_ACTIVE);
  end

  assign o_frame_done  = done_reg;
  assign o_frame_error = error_reg;
  assign o_bit_count   = bit_count_reg;

`ifdef WS2812_FRAME_CTRL_STATS_EN
  logic [15:0] frame_count_reg;
  logic [7:0]  error_count_reg;

  // Counters advance with the pulse so they read current while the pulse is visible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      frame_count_reg <= '0;
      error_count_reg <= '0;
    end else begin
      if (done_next)
        frame_count_reg <= frame_count_reg + 16'd1;
      if (error_next && (error_count_reg != 8'hFF))
        error_count_reg <= error_count_reg + 8'd1;
    end
  end

  assign o_frame_count = frame_count_reg;
  assign o_error_count = error_count_reg;
`else
  assign o_frame_count = 16'd0;
  assign o_error_count = 8'd0;
`endif

endmodule
